// File: rtl/reg_pipe_chain.sv
// reg_pipe_chain: elastic register chain of DEPTH stages with per-stage
// valid bits and a valid/ready handshake. Bubbles collapse; backpressure
// only stalls stages that are full. DEPTH=0 is a combinational pass-through.
module reg_pipe_chain #(
  parameter int DATAWIDTH = 18,
  parameter int DEPTH     = 2,
  parameter int CNTW      = 4
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 clkenable,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out,
  output logic [CNTW-1:0]      count
);

  generate
    if (DEPTH == 0) begin : g_pass
      // No storage: handshake and data pass straight through, gated by enable/flush
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, CLK, rst};

      assign in_ready  = out_ready & clkenable & ~flush;
      assign out_valid = in_valid & clkenable & ~flush;
      assign out       = in1;
      assign count     = '0;
    end else begin : g_regs
      localparam int unsigned NST = DEPTH;

      logic [DEPTH-1:0]     v;
      logic [DATAWIDTH-1:0] d     [DEPTH];
      logic [DEPTH-1:0]     rdy;
      logic [DEPTH-1:0]     vprev;
      logic [DATAWIDTH-1:0] dprev [DEPTH];
      logic [CNTW-1:0]      cnt;

      // Ready ripples from the output back to the input; a scalar accumulator
      // avoids a self-referencing vector in the combinational loop.
      always_comb begin
        logic r;
        rdy = '0;
        r   = out_ready;
        for (int unsigned k = 0; k < NST; k++) begin
          r = ~v[NST-1-k] | r;
          rdy[NST-1-k] = r;
        end
      end

      // Upstream neighbour of each stage; stage 0 is fed by the producer
      always_comb begin
        vprev[0] = in_valid;
        dprev[0] = in1;
        for (int unsigned i = 1; i < NST; i++) begin
          vprev[i] = v[i-1];
          dprev[i] = d[i-1];
        end
      end

      // Occupancy is the population count of the valid bits
      always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < NST; i++) begin
          cnt = cnt + CNTW'(v[i]);
        end
      end

      // Stage registers: flush clears valids only; ready stages take upstream
      always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
          v <= '0;
          for (int unsigned i = 0; i < NST; i++) begin
            d[i] <= '0;
          end
        end else if (flush) begin
          v <= '0;
        end else if (clkenable) begin
          for (int unsigned i = 0; i < NST; i++) begin
            if (rdy[i]) begin
              v[i] <= vprev[i];
              if (vprev[i]) begin
                d[i] <= dprev[i];
              end
            end
          end
        end
      end

      assign in_ready  = rdy[0] & clkenable & ~flush;
      assign out_valid = v[DEPTH-1];
      assign out       = d[DEPTH-1];
      assign count     = cnt;
    end
  endgenerate

endmodule

// File: tb/tb_reg_pipe_chain.sv
// Testbench for reg_pipe_chain: DEPTH=3, DEPTH=2 and DEPTH=0 instances share
// one stimulus; table vectors, directed corner sequences, then random traffic
// checked against an item-list reference model.
module tb_reg_pipe_chain;

  logic        CLK = 1'b0;
  logic        rst, clkenable, flush, in_valid, out_ready;
  logic [17:0] in1;

  logic        ir3, ov3, ir2, ov2, ir0, ov0;
  logic [17:0] o3, o2, o0;
  logic [3:0]  c3, c2, c0;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  reg_pipe_chain #(.DATAWIDTH(18), .DEPTH(3), .CNTW(4)) u3 (
    .CLK(CLK), .rst(rst), .clkenable(clkenable), .flush(flush),
    .in_valid(in_valid), .in_ready(ir3), .in1(in1),
    .out_valid(ov3), .out_ready(out_ready), .out(o3), .count(c3));

  reg_pipe_chain #(.DATAWIDTH(18), .DEPTH(2), .CNTW(4)) u2 (
    .CLK(CLK), .rst(rst), .clkenable(clkenable), .flush(flush),
    .in_valid(in_valid), .in_ready(ir2), .in1(in1),
    .out_valid(ov2), .out_ready(out_ready), .out(o2), .count(c2));

  reg_pipe_chain #(.DATAWIDTH(18), .DEPTH(0), .CNTW(4)) u0 (
    .CLK(CLK), .rst(rst), .clkenable(clkenable), .flush(flush),
    .in_valid(in_valid), .in_ready(ir0), .in1(in1),
    .out_valid(ov0), .out_ready(out_ready), .out(o0), .count(c0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp3(input string tag, input logic ov, input logic [17:0] o,
                      input logic [3:0] c, input logic ir);
    chk({tag, " u3.out_valid"}, 32'(ov3), 32'(ov));
    chk({tag, " u3.out"},       32'(o3),  32'(o));
    chk({tag, " u3.count"},     32'(c3),  32'(c));
    chk({tag, " u3.in_ready"},  32'(ir3), 32'(ir));
  endtask

  task automatic exp2(input string tag, input logic ov, input logic [17:0] o,
                      input logic [3:0] c, input logic ir);
    chk({tag, " u2.out_valid"}, 32'(ov2), 32'(ov));
    chk({tag, " u2.out"},       32'(o2),  32'(o));
    chk({tag, " u2.count"},     32'(c2),  32'(c));
    chk({tag, " u2.in_ready"},  32'(ir2), 32'(ir));
  endtask

  // Reference model: each chain is a list of items (oldest first) with the
  // stage position each item currently sits in; out shows the last item that
  // reached the final stage.
  int          mdep [2] = '{3, 2};
  int          mn   [2];
  int          mpos [2][8];
  logic [17:0] mdat [2][8];
  logic [17:0] mstale [2];

  task automatic mreset();
    for (int m = 0; m < 2; m++) begin
      mn[m] = 0;
      mstale[m] = '0;
    end
  endtask

  // Position just behind which the next item may advance, after all items move
  function automatic int mbound(int m, logic ordy);
    int b;
    b = ordy ? mdep[m] + 1 : mdep[m];
    for (int k = 0; k < mn[m]; k++)
      b = (mpos[m][k] + 1 < b) ? mpos[m][k] + 1 : mpos[m][k];
    return b;
  endfunction

  task automatic mstep(input int m, input logic iv, input logic [17:0] din,
                       input logic ordy, input logic ce, input logic fl);
    int b, np, keep;
    int npos [8];
    logic [17:0] ndat [8];
    if (fl) begin
      mn[m] = 0;
      return;
    end
    if (!ce) return;
    b = ordy ? mdep[m] + 1 : mdep[m];
    keep = 0;
    for (int k = 0; k < mn[m]; k++) begin
      np = (mpos[m][k] + 1 < b) ? mpos[m][k] + 1 : mpos[m][k];
      b = np;
      if (np < mdep[m]) begin
        if (np == mdep[m] - 1 && np != mpos[m][k]) mstale[m] = mdat[m][k];
        npos[keep] = np;
        ndat[keep] = mdat[m][k];
        keep++;
      end
    end
    if (iv && b > 0) begin
      npos[keep] = 0;
      ndat[keep] = din;
      keep++;
    end
    for (int k = 0; k < keep; k++) begin
      mpos[m][k] = npos[k];
      mdat[m][k] = ndat[k];
    end
    mn[m] = keep;
  endtask

  task automatic do_reset();
    in_valid = 0; in1 = '0; out_ready = 1; clkenable = 1; flush = 0;
    rst = 1;
    mreset();
    @(posedge CLK);
    #2 rst = 0;
  endtask

  task automatic drive(input logic iv, input logic [17:0] din, input logic ordy);
    in_valid = iv; in1 = din; out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  typedef struct {
    logic        iv;
    logic [17:0] din;
    logic        ordy;
    logic        ov;
    logic [17:0] o;
    logic [3:0]  c;
    logic        ir;
  } vec_t;

  vec_t tv [9];

  initial begin
    logic exp_ov;
    logic exp_ir;
    logic [17:0] rin;
    logic riv, rordy, rce, rfl;

    // DEPTH=3 streaming, out_ready held high: latency 3, one item per cycle
    tv[0] = '{1'b1, 18'h1, 1'b1, 1'b0, 18'h0, 4'd0, 1'b1};
    tv[1] = '{1'b1, 18'h2, 1'b1, 1'b0, 18'h0, 4'd1, 1'b1};
    tv[2] = '{1'b1, 18'h3, 1'b1, 1'b0, 18'h0, 4'd2, 1'b1};
    tv[3] = '{1'b1, 18'h4, 1'b1, 1'b1, 18'h1, 4'd3, 1'b1};
    tv[4] = '{1'b1, 18'h5, 1'b1, 1'b1, 18'h2, 4'd3, 1'b1};
    tv[5] = '{1'b0, 18'h0, 1'b1, 1'b1, 18'h3, 4'd3, 1'b1};
    tv[6] = '{1'b0, 18'h0, 1'b1, 1'b1, 18'h4, 4'd2, 1'b1};
    tv[7] = '{1'b0, 18'h0, 1'b1, 1'b1, 18'h5, 4'd1, 1'b1};
    tv[8] = '{1'b0, 18'h0, 1'b1, 1'b0, 18'h5, 4'd0, 1'b1};

    do_reset();
    exp3("reset", 1'b0, 18'h0, 4'd0, 1'b1);
    chk("reset u2.out_valid", 32'(ov2), 32'd0);

    for (int i = 0; i < 9; i++) begin
      drive(tv[i].iv, tv[i].din, tv[i].ordy);
      #1;
      exp3($sformatf("stream[%0d]", i), tv[i].ov, tv[i].o, tv[i].c, tv[i].ir);
      tick();
    end

    // DEPTH=3 backpressure: fills to 3, in_ready drops, then drains in order
    do_reset();
    drive(1, 18'h1, 0); #1 exp3("bp c0", 0, 18'h0, 4'd0, 1); tick();
    drive(1, 18'h2, 0); #1 exp3("bp c1", 0, 18'h0, 4'd1, 1); tick();
    drive(1, 18'h3, 0); #1 exp3("bp c2", 0, 18'h0, 4'd2, 1); tick();
    drive(1, 18'h4, 0); #1 exp3("bp c3", 1, 18'h1, 4'd3, 0); tick();
    drive(1, 18'h4, 0); #1 exp3("bp c4", 1, 18'h1, 4'd3, 0); tick();
    drive(1, 18'h4, 1); #1 exp3("bp c5", 1, 18'h1, 4'd3, 1); tick();
    drive(0, 18'h0, 1); #1 exp3("bp c6", 1, 18'h2, 4'd3, 1); tick();
    drive(0, 18'h0, 1); #1 exp3("bp c7", 1, 18'h3, 4'd2, 1); tick();
    drive(0, 18'h0, 1); #1 exp3("bp c8", 1, 18'h4, 4'd1, 1); tick();
    drive(0, 18'h0, 1); #1 exp3("bp c9", 0, 18'h4, 4'd0, 1); tick();

    // DEPTH=2 out_ready toggling with in_valid held: bubbles collapse, no duplicate
    do_reset();
    drive(1, 18'h1, 1); #1 exp2("tog c0", 0, 18'h0, 4'd0, 1); tick();
    drive(1, 18'h2, 0); #1 exp2("tog c1", 0, 18'h0, 4'd1, 1); tick();
    drive(1, 18'h3, 1); #1 exp2("tog c2", 1, 18'h1, 4'd2, 1); tick();
    drive(1, 18'h4, 0); #1 exp2("tog c3", 1, 18'h2, 4'd2, 0); tick();
    drive(0, 18'h0, 1); #1 exp2("tog c4", 1, 18'h2, 4'd2, 1); tick();
    drive(0, 18'h0, 1); #1 exp2("tog c5", 1, 18'h3, 4'd1, 1); tick();
    drive(0, 18'h0, 1); #1 exp2("tog c6", 0, 18'h3, 4'd0, 1); tick();

    // DEPTH=3 flush with a full chain; the flush-cycle input is refused
    do_reset();
    drive(1, 18'h1, 0); tick();
    drive(1, 18'h2, 0); tick();
    drive(1, 18'h3, 0); tick();
    drive(1, 18'h9, 1); flush = 1;
    #1 exp3("flush cyc", 1, 18'h1, 4'd3, 0);
    tick();
    flush = 0; drive(0, 18'h0, 1);
    #1 exp3("after flush", 0, 18'h1, 4'd0, 1);
    tick();
    #1 exp3("after flush+1", 0, 18'h1, 4'd0, 1);

    // DEPTH=2 clkenable freeze mid-stream, then resume
    do_reset();
    drive(1, 18'h1, 1); tick();
    drive(1, 18'h2, 1); tick();
    clkenable = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 18'h3, 1);
      #1 exp2($sformatf("freeze[%0d]", i), 1, 18'h1, 4'd2, 0);
      tick();
    end
    clkenable = 1;
    drive(1, 18'h3, 1); #1 exp2("resume c0", 1, 18'h1, 4'd2, 1); tick();
    drive(0, 18'h0, 1); #1 exp2("resume c1", 1, 18'h2, 4'd2, 1); tick();
    drive(0, 18'h0, 1); #1 exp2("resume c2", 1, 18'h3, 4'd1, 1); tick();
    drive(0, 18'h0, 1); #1 exp2("resume c3", 0, 18'h3, 4'd0, 1); tick();

    // Asynchronous reset between edges with two items in DEPTH=2
    do_reset();
    drive(1, 18'h11, 0); tick();
    drive(1, 18'h22, 0); tick();
    drive(0, 18'h0, 0);
    #1 exp2("pre-rst", 1, 18'h11, 4'd2, 0);
    #1 rst = 1;
    #1 exp2("async rst", 0, 18'h0, 4'd0, 1);
    chk("async rst u3.count", 32'(c3), 32'd0);
    tick();
    rst = 0;

    // DEPTH=0 pass-through follows in1 with no clock edge
    drive(1, 18'h2A, 1);
    #1 chk("d0 out", 32'(o0), 32'h2A);
    chk("d0 out_valid", 32'(ov0), 32'd1);
    in1 = 18'h3FFFF;
    #1 chk("d0 out track", 32'(o0), 32'h3FFFF);
    out_ready = 0;
    #1 chk("d0 in_ready low", 32'(ir0), 32'd0);
    flush = 1; out_ready = 1;
    #1 chk("d0 flush out_valid", 32'(ov0), 32'd0);
    chk("d0 flush in_ready", 32'(ir0), 32'd0);
    flush = 0;

    // Random traffic against the reference model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      riv   = ($urandom_range(99, 0) < 60);
      rin   = 18'($urandom);
      rordy = ($urandom_range(99, 0) < 65);
      rce   = ($urandom_range(99, 0) < 90);
      rfl   = ($urandom_range(99, 0) < 4);
      drive(riv, rin, rordy);
      clkenable = rce; flush = rfl;
      #1;
      exp_ov = (mn[0] > 0) && (mpos[0][0] == 2);
      exp_ir = rce && !rfl && (mbound(0, rordy) > 0);
      exp3($sformatf("rand[%0d]", n), exp_ov, mstale[0], 4'(mn[0]), exp_ir);
      exp_ov = (mn[1] > 0) && (mpos[1][0] == 1);
      exp_ir = rce && !rfl && (mbound(1, rordy) > 0);
      exp2($sformatf("rand[%0d]", n), exp_ov, mstale[1], 4'(mn[1]), exp_ir);
      chk($sformatf("rand[%0d] u0.out", n), 32'(o0), 32'(rin));
      chk($sformatf("rand[%0d] u0.out_valid", n), 32'(ov0), 32'(riv & rce & !rfl));
      chk($sformatf("rand[%0d] u0.in_ready", n), 32'(ir0), 32'(rordy & rce & !rfl));
      chk($sformatf("rand[%0d] u0.count", n), 32'(c0), 32'd0);
      @(posedge CLK);
      mstep(0, riv, rin, rordy, rce, rfl);
      mstep(1, riv, rin, rordy, rce, rfl);
      #2;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
